a2d_scheduler: RTL and testbench

Round-robin conversion scheduler for the off-chip A2D (ADC128S) shared by the left/right load cells, steering pot and battery monitor. On each `nxt` trigger it runs the two-transaction ADC128S sequence through the existing 16-bit SPI monarch: send the channel address, wait a settle gap, then send again and capture the result. It holds one registered 12-bit result per source. It sits between the SPI monarch and the rider-detect, steer-enable and battery-check logic inside `Segway`. Battery is sampled at a reduced rate set by `BATT_DIV`.

---
 rtl/a2d_pkg.sv | 35 +++
 rtl/a2d_scheduler_if.sv | 10 +
 rtl/a2d_scheduler.sv | 122 ++++++++++++
 tb/tb_a2d_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D round-robin conversion scheduler.
package a2d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WAIT1  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RD     = 3'd4,
        ST_WAIT2  = 3'd5
    } a2d_state_t;

    typedef enum logic [1:0] {
        SLOT_LFT   = 2'd0,
        SLOT_RGHT  = 2'd1,
        SLOT_STEER = 2'd2,
        SLOT_BATT  = 2'd3
    } a2d_slot_t;

    // ADC128S channel addressed by each slot.
    localparam logic [2:0] A2D_CHNL [4] = '{3'd0, 3'd4, 3'd5, 3'd6};

    // Round-robin order; battery is only inserted after steer on its due round.
    function automatic a2d_slot_t a2d_next_slot(input a2d_slot_t cur, input logic batt_due);
        a2d_slot_t nxt_slot;
        case (cur)
            SLOT_LFT:   nxt_slot = SLOT_RGHT;
            SLOT_RGHT:  nxt_slot = SLOT_STEER;
            SLOT_STEER: nxt_slot = batt_due ? SLOT_BATT : SLOT_LFT;
            default:    nxt_slot = SLOT_LFT;
        endcase
        return nxt_slot;
    endfunction

endpackage

// File: rtl/a2d_scheduler_if.sv
// Handshake between the scheduler and the shared 16-bit SPI monarch.
interface a2d_scheduler_if;
    logic        wrt;
    logic [15:0] wt_data;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output wt_data, input done, input rd_data);
    modport slave  (input wrt, input wt_data, output done, output rd_data);
endinterface

// File: rtl/a2d_scheduler.sv
// Round-robin ADC128S conversion scheduler: two SPI transactions per conversion
// (address, settle gap, address again + capture) with one result register per source.
module a2d_scheduler
    import a2d_pkg::*;
#(
    parameter int SETTLE   = 2,
    parameter int BATT_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    a2d_scheduler_if.master         spi,
    input  logic                    nxt,
    input  logic                    ovr_clr,
    output logic [11:0]             lft_ld,
    output logic [11:0]             rght_ld,
    output logic [11:0]             steer_pot,
    output logic [11:0]             batt,
    output logic                    smpl_vld,
    output logic [1:0]              smpl_slot,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [3:0] RND_LAST  = 4'(BATT_DIV - 1);

    a2d_state_t state, state_nxt;
    a2d_slot_t  slot;
    logic [3:0] rnd;
    logic [3:0] settle_cnt;
    logic       capture;
    logic       batt_due;
    logic       unused_rd_hi;

    assign batt_due     = (rnd == RND_LAST);
    assign busy         = (state != ST_IDLE);
    assign spi.wrt      = (state == ST_CMD) || (state == ST_RD);
    assign capture      = (state == ST_WAIT2) && spi.done;
    assign unused_rd_hi = ^spi.rd_data[15:12];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; done is only honoured while waiting on a transaction.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (nxt) state_nxt = ST_CMD;
            ST_CMD:    state_nxt = ST_WAIT1;
            ST_WAIT1:  if (spi.done) state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == 4'd0) state_nxt = ST_RD;
            ST_RD:     state_nxt = ST_WAIT2;
            ST_WAIT2:  if (spi.done) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Settle gap down-counter, loaded as the first transaction completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 4'd0;
        end else if ((state == ST_WAIT1) && spi.done) begin
            settle_cnt <= SETTLE_LD;
        end else if ((state == ST_SETTLE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Command word is latched on trigger acceptance and held for both transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi.wt_data <= 16'h0000;
        end else if ((state == ST_IDLE) && nxt) begin
            spi.wt_data <= {2'b00, A2D_CHNL[slot], 11'h000};
        end
    end

    // Slot pointer and battery round counter advance on each captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= SLOT_LFT;
            rnd  <= 4'd0;
        end else if (capture) begin
            slot <= a2d_next_slot(slot, batt_due);
            if (slot == SLOT_STEER) rnd <= batt_due ? 4'd0 : rnd + 4'd1;
        end
    end

    // Result registers and update strobe; a reset mid-conversion discards everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
            smpl_vld  <= 1'b0;
            smpl_slot <= 2'd0;
        end else begin
            smpl_vld <= capture;
            if (capture) begin
                smpl_slot <= slot;
                case (slot)
                    SLOT_LFT:   lft_ld    <= spi.rd_data[11:0];
                    SLOT_RGHT:  rght_ld   <= spi.rd_data[11:0];
                    SLOT_STEER: steer_pot <= spi.rd_data[11:0];
                    default:    batt      <= spi.rd_data[11:0];
                endcase
            end
        end
    end

    // Sticky overrun: a dropped trigger beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               overrun <= 1'b0;
        else if (nxt && busy)  overrun <= 1'b1;
        else if (ovr_clr)      overrun <= 1'b0;
    end

endmodule

// File: tb/tb_a2d_scheduler.sv
// Directed bench for a2d_scheduler: three instances (SETTLE/BATT_DIV = 2/4, 1/1, 15/4),
// each paired with a behavioural SPI monarch + ADC128S model.
module tb_a2d_scheduler;

    localparam int NDUT = 3;
    localparam int SETTLE_V [NDUT] = '{2, 1, 15};
    localparam int BDIV_V   [NDUT] = '{4, 1, 4};
    localparam int SPI_LAT = 6;

    logic clk = 1'b0;
    logic rst;
    logic nxt [NDUT];
    logic ovr_clr [NDUT];
    logic spur [NDUT];

    logic [11:0] lft_w [NDUT];
    logic [11:0] rght_w [NDUT];
    logic [11:0] steer_w [NDUT];
    logic [11:0] batt_w [NDUT];
    logic        vld_w [NDUT];
    logic [1:0]  slot_w [NDUT];
    logic        busy_w [NDUT];
    logic        ovr_w [NDUT];
    logic        wrt_w [NDUT];
    logic [15:0] wt_w [NDUT];
    logic        done_w [NDUT];
    int          gap_w [NDUT];

    logic [11:0] adc_val [8];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic [15:0] wt_hist [$];
    int          slot_hist [$];
    int          vld_cnt = 0;

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_u
        a2d_scheduler_if bus();
        logic        mdl_done = 1'b0;
        logic [15:0] mdl_rd = 16'h0;
        logic        pend = 1'b0;
        int          cnt = 0;
        logic [2:0]  cur_ch = 3'd0;
        logic [2:0]  last_ch = 3'd0;
        logic        armed = 1'b0;
        int          wrt_cnt = 0;
        int          done_cyc = 0;
        int          gap = 0;

        a2d_scheduler #(.SETTLE(SETTLE_V[g]), .BATT_DIV(BDIV_V[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .spi       (bus),
            .nxt       (nxt[g]),
            .ovr_clr   (ovr_clr[g]),
            .lft_ld    (lft_w[g]),
            .rght_ld   (rght_w[g]),
            .steer_pot (steer_w[g]),
            .batt      (batt_w[g]),
            .smpl_vld  (vld_w[g]),
            .smpl_slot (slot_w[g]),
            .busy      (busy_w[g]),
            .overrun   (ovr_w[g])
        );

        assign bus.done    = mdl_done | spur[g];
        assign bus.rd_data = mdl_rd;
        assign wrt_w[g]    = bus.wrt;
        assign wt_w[g]     = bus.wt_data;
        assign done_w[g]   = bus.done;
        assign gap_w[g]    = gap;

        // SPI monarch + ADC128S: each reply carries the channel addressed by the previous command.
        always @(posedge clk) begin
            mdl_done <= 1'b0;
            if (bus.wrt) begin
                pend   <= 1'b1;
                cnt    <= SPI_LAT;
                cur_ch <= bus.wt_data[13:11];
            end else if (pend) begin
                if (cnt == 0) begin
                    mdl_done <= 1'b1;
                    mdl_rd   <= {4'hA, adc_val[last_ch]};
                    last_ch  <= cur_ch;
                    pend     <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end

        // Measure cycles from first-transaction done to the second wrt.
        always @(negedge clk) begin
            if (rst) begin
                wrt_cnt <= 0;
                armed   <= 1'b0;
            end else if (bus.wrt) begin
                wrt_cnt <= wrt_cnt + 1;
                if (wrt_cnt[0]) gap <= cyc - done_cyc;
                else            armed <= 1'b1;
            end else if (bus.done && armed) begin
                done_cyc <= cyc;
                armed    <= 1'b0;
            end
        end
    end

    // History of command words and updated slots for the main instance.
    always @(negedge clk) begin
        if (wrt_w[0]) wt_hist.push_back(wt_w[0]);
        if (vld_w[0]) begin
            slot_hist.push_back(int'(slot_w[0]));
            vld_cnt <= vld_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_nxt(input int g);
        nxt[g] = 1'b1;
        @(negedge clk);
        nxt[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        for (int i = 0; i < 400; i++) begin
            if (!busy_w[g]) break;
            @(negedge clk);
        end
        chk("idle_timeout", 64'(busy_w[g]), 64'd0);
    endtask

    // Returns in the first SETTLE cycle of the conversion in progress.
    task automatic wait_settle(input int g);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_w[g]) break;
        end
        chk("done_timeout", 64'(done_w[g]), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bw, bs, vb, n3000;
        int exp_slots [16];
        exp_slots = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 0, 1, 2};

        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            nxt[i] = 1'b0;
            ovr_clr[i] = 1'b0;
            spur[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) adc_val[i] = 12'hFFF;
        adc_val[0] = 12'h300;
        adc_val[4] = 12'h300;
        adc_val[5] = 12'h800;
        adc_val[6] = 12'hC00;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        chk("rst_busy", 64'(busy_w[0]), 64'd0);
        chk("rst_wrt", 64'(wrt_w[0]), 64'd0);
        chk("rst_wt_data", 64'(wt_w[0]), 64'd0);
        chk("rst_results", {lft_w[0], rght_w[0], steer_w[0], batt_w[0]}, 64'd0);
        chk("rst_vld_slot", {vld_w[0], slot_w[0]}, 64'd0);
        chk("rst_overrun", 64'(ovr_w[0]), 64'd0);

        // Three conversions: lft, rght, steer
        bw = wt_hist.size();
        pulse_nxt(0);
        chk("start_wrt", 64'(wrt_w[0]), 64'd1);
        chk("start_busy", 64'(busy_w[0]), 64'd1);
        tick(1);
        chk("wrt_one_cycle", 64'(wrt_w[0]), 64'd0);
        wait_idle(0);
        chk("c1_vld_slot", {vld_w[0], slot_w[0]}, {1'b1, 2'd0});
        chk("c1_lft", 64'(lft_w[0]), 64'h300);
        tick(1);
        chk("vld_pulse_end", 64'(vld_w[0]), 64'd0);
        pulse_nxt(0);
        wait_idle(0);
        chk("c2_vld_slot", {vld_w[0], slot_w[0]}, {1'b1, 2'd1});
        chk("c2_rght", 64'(rght_w[0]), 64'h300);
        pulse_nxt(0);
        chk("b2b_wrt", 64'(wrt_w[0]), 64'd1);
        chk("b2b_no_overrun", 64'(ovr_w[0]), 64'd0);
        wait_idle(0);
        chk("c3_steer", 64'(steer_w[0]), 64'h800);
        chk("c3_batt_zero", 64'(batt_w[0]), 64'd0);
        chk("wt_count", 64'(wt_hist.size() - bw), 64'd6);
        chk("wt_c1", {wt_hist[bw], wt_hist[bw+1]}, {16'h0000, 16'h0000});
        chk("wt_c2", {wt_hist[bw+2], wt_hist[bw+3]}, {16'h2000, 16'h2000});
        chk("wt_c3", {wt_hist[bw+4], wt_hist[bw+5]}, {16'h2800, 16'h2800});
        chk("gap_settle2", 64'(gap_w[0]), 64'd3);
        tick(2);

        // Sixteen conversions from reset with BATT_DIV=4
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        adc_val[4] = 12'h340;
        bw = wt_hist.size();
        bs = slot_hist.size();
        for (int i = 0; i < 16; i++) begin
            pulse_nxt(0);
            wait_idle(0);
            tick(1);
        end
        chk("run16_count", 64'(slot_hist.size() - bs), 64'd16);
        for (int i = 0; i < 16; i++) chk($sformatf("run16_slot%0d", i), 64'(slot_hist[bs+i]), 64'(exp_slots[i]));
        n3000 = 0;
        for (int i = bw; i < wt_hist.size(); i++) if (wt_hist[i] == 16'h3000) n3000++;
        chk("run16_batt_cmds", 64'(n3000), 64'd2);
        chk("run16_batt", 64'(batt_w[0]), 64'hC00);
        chk("run16_rght", 64'(rght_w[0]), 64'h340);

        // Overrun: trigger dropped during WAIT1
        pulse_nxt(0);
        tick(2);
        vb = vld_cnt;
        pulse_nxt(0);
        chk("ovr_set", 64'(ovr_w[0]), 64'd1);
        wait_idle(0);
        tick(5);
        chk("ovr_one_conv", 64'(vld_cnt - vb), 64'd1);
        chk("ovr_stays_idle", 64'(busy_w[0]), 64'd0);
        chk("ovr_sticky", 64'(ovr_w[0]), 64'd1);
        ovr_clr[0] = 1'b1;
        tick(1);
        ovr_clr[0] = 1'b0;
        chk("ovr_clr", 64'(ovr_w[0]), 64'd0);
        pulse_nxt(0);
        tick(2);
        nxt[0] = 1'b1;
        ovr_clr[0] = 1'b1;
        tick(1);
        nxt[0] = 1'b0;
        ovr_clr[0] = 1'b0;
        chk("ovr_set_wins", 64'(ovr_w[0]), 64'd1);
        wait_idle(0);
        tick(2);

        // Spurious done in IDLE
        vb = vld_cnt;
        spur[0] = 1'b1;
        tick(1);
        spur[0] = 1'b0;
        chk("spur_idle_busy", 64'(busy_w[0]), 64'd0);
        tick(2);
        chk("spur_idle_vld", 64'(vld_cnt - vb), 64'd0);

        // Spurious done in SETTLE (next slot is steer)
        vb = vld_cnt;
        pulse_nxt(0);
        wait_settle(0);
        spur[0] = 1'b1;
        tick(1);
        spur[0] = 1'b0;
        wait_idle(0);
        tick(1);
        chk("spur_settle_gap", 64'(gap_w[0]), 64'd3);
        chk("spur_settle_vld", 64'(vld_cnt - vb), 64'd1);
        chk("spur_settle_slot", 64'(slot_w[0]), 64'd2);
        chk("spur_settle_wt", 64'(wt_hist[wt_hist.size()-1]), 64'h2800);

        // Reset asserted during SETTLE
        pulse_nxt(0);
        wait_settle(0);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy_w[0]), 64'd0);
        chk("rst_mid_wrt", 64'(wrt_w[0]), 64'd0);
        tick(1);
        chk("rst_mid_results", {lft_w[0], rght_w[0], steer_w[0], batt_w[0]}, 64'd0);
        chk("rst_mid_overrun", 64'(ovr_w[0]), 64'd0);
        rst = 1'b0;
        tick(12);
        bw = wt_hist.size();
        pulse_nxt(0);
        wait_idle(0);
        chk("post_rst_wt", 64'(wt_hist[bw]), 64'h0000);
        chk("post_rst_slot", {vld_w[0], slot_w[0]}, {1'b1, 2'd0});
        chk("post_rst_lft", 64'(lft_w[0]), 64'h300);
        tick(2);

        // SETTLE=1, BATT_DIV=1: battery every round
        for (int i = 0; i < 4; i++) begin
            pulse_nxt(1);
            wait_idle(1);
            tick(1);
        end
        chk("s1_gap", 64'(gap_w[1]), 64'd2);
        chk("s1_batt", 64'(batt_w[1]), 64'hC00);
        chk("s1_slot", 64'(slot_w[1]), 64'd3);
        chk("s1_steer", 64'(steer_w[1]), 64'h800);

        // SETTLE=15
        pulse_nxt(2);
        wait_idle(2);
        chk("s15_gap", 64'(gap_w[2]), 64'd16);
        chk("s15_lft", 64'(lft_w[2]), 64'h300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
